// File: rtl/aes_uart_pkg.sv
// Shared types and widths for the UART-fed AES receive/decrypt/transmit controller.
package aes_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DECRYPT,
        ST_SEND,
        ST_GAP
    } state_t;

    localparam int BYTE_CNT_W = 5;
    localparam int TIMER_W    = 20;

    localparam logic [BYTE_CNT_W-1:0] BLOCK_BYTES = 5'd16;
    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE   = 5'd15;

endpackage

// File: rtl/aes_rx_decrypt_ctrl_if.sv
// Handshake between the frame controller (master) and the AES decryption core (slave).
interface aes_rx_decrypt_ctrl_if;

    logic         dec_start;
    logic [127:0] dec_ciphertext;
    logic [127:0] dec_key;
    logic         dec_done;
    logic [127:0] dec_plaintext;

    modport master (
        output dec_start,
        output dec_ciphertext,
        output dec_key,
        input  dec_done,
        input  dec_plaintext
    );

    modport slave (
        input  dec_start,
        input  dec_ciphertext,
        input  dec_key,
        output dec_done,
        output dec_plaintext
    );

endinterface

// File: rtl/cycle_timer.sv
// Loadable down-counter; expired is high once the count has reached zero.
module cycle_timer
    import aes_uart_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         enable,
    input  logic [W-1:0] load_value,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/aes_rx_decrypt_ctrl.sv
// Collects 16 UART bytes into an AES block, runs the decryption core, then
// returns the plaintext over UART one byte at a time with a fixed inter-byte gap.
//
// state    | meaning
// IDLE     | waiting for the first byte of a frame
// COLLECT  | assembling bytes 2..16, inactivity timer running
// DECRYPT  | dec_start issued, waiting for dec_done
// SEND     | tx_dv issued for one byte, waiting for tx_done
// GAP      | idle spacing before the next plaintext byte
module aes_rx_decrypt_ctrl
    import aes_uart_pkg::*;
#(
    parameter int           TIMEOUT_CYCLES = 1000000,
    parameter int           GAP_CYCLES     = 100000,
    parameter logic [127:0] KEY            = 128'h6d6120686f6f6f6f6f6e20726f686974
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx_dv,
    input  logic [7:0]            rx_byte,
    output logic                  tx_dv,
    output logic [7:0]            tx_byte,
    input  logic                  tx_done,
    output logic [127:0]          plain_data,
    output logic                  frame_valid,
    output logic                  timeout_err,
    output logic                  overrun_err,
    output logic [7:0]            frame_count,
    aes_rx_decrypt_ctrl_if.master dec
);

    // Timer is loaded with N-1 so that expiry coincides with the N-th idle clock.
    localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD     = TIMER_W'(GAP_CYCLES - 1);

    state_t                 state, state_nxt;
    logic [BYTE_CNT_W-1:0]  rx_cnt, tx_cnt;
    logic [127:0]           cipher_q, tx_shift;
    logic                   dec_start_q;

    logic                   timer_load, timer_en, timer_expired;
    logic [TIMER_W-1:0]     timer_value;

    logic first_byte, next_byte, launch, capture, send_next, timeout_hit, overrun_hit;

    cycle_timer #(.W(TIMER_W)) u_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (timer_load),
        .enable     (timer_en),
        .load_value (timer_value),
        .expired    (timer_expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        first_byte  = 1'b0;
        next_byte   = 1'b0;
        launch      = 1'b0;
        capture     = 1'b0;
        send_next   = 1'b0;
        timeout_hit = 1'b0;
        overrun_hit = 1'b0;
        timer_load  = 1'b0;
        timer_en    = 1'b0;
        timer_value = TIMEOUT_LOAD;
        case (state)
            ST_IDLE: begin
                if (rx_dv) begin
                    first_byte = 1'b1;
                    timer_load = 1'b1;
                    state_nxt  = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                // A byte landing on the expiry clock wins over the timeout.
                if (rx_dv) begin
                    next_byte  = 1'b1;
                    timer_load = 1'b1;
                    if (rx_cnt == LAST_BYTE) begin
                        launch    = 1'b1;
                        state_nxt = ST_DECRYPT;
                    end
                end else if (timer_expired) begin
                    timeout_hit = 1'b1;
                    state_nxt   = ST_IDLE;
                end else begin
                    timer_en = 1'b1;
                end
            end
            ST_DECRYPT: begin
                overrun_hit = rx_dv;
                if (dec.dec_done) begin
                    capture   = 1'b1;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                overrun_hit = rx_dv;
                if (tx_done) begin
                    if (tx_cnt == BLOCK_BYTES) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        timer_load  = 1'b1;
                        timer_value = GAP_LOAD;
                        state_nxt   = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                overrun_hit = rx_dv;
                if (timer_expired) begin
                    send_next = 1'b1;
                    state_nxt = ST_SEND;
                end else begin
                    timer_en = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cipher_q    <= '0;
            tx_shift    <= '0;
            rx_cnt      <= '0;
            tx_cnt      <= '0;
            dec_start_q <= 1'b0;
            tx_dv       <= 1'b0;
            tx_byte     <= '0;
            plain_data  <= '0;
            frame_valid <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
            frame_count <= '0;
        end else begin
            dec_start_q <= launch;
            tx_dv       <= capture | send_next;
            timeout_err <= timeout_hit;
            overrun_err <= overrun_hit;
            if (first_byte) begin
                cipher_q    <= {rx_byte, 120'd0};
                rx_cnt      <= BYTE_CNT_W'(1);
                frame_valid <= 1'b0;
            end
            if (next_byte) begin
                // Byte k of the frame lands at bits [127-8k -: 8]; ~k gives 15-k.
                cipher_q[{~rx_cnt[3:0], 3'b000} +: 8] <= rx_byte;
                rx_cnt <= rx_cnt + BYTE_CNT_W'(1);
            end
            if (timeout_hit) begin
                cipher_q <= '0;
                rx_cnt   <= '0;
            end
            if (capture) begin
                plain_data  <= dec.dec_plaintext;
                tx_byte     <= dec.dec_plaintext[127:120];
                tx_shift    <= {dec.dec_plaintext[119:0], 8'd0};
                tx_cnt      <= BYTE_CNT_W'(1);
                rx_cnt      <= '0;
                frame_valid <= 1'b1;
                frame_count <= frame_count + 8'd1;
            end
            if (send_next) begin
                tx_byte  <= tx_shift[127:120];
                tx_shift <= {tx_shift[119:0], 8'd0};
                tx_cnt   <= tx_cnt + BYTE_CNT_W'(1);
            end
        end
    end

    assign dec.dec_start      = dec_start_q;
    assign dec.dec_ciphertext = cipher_q;
    assign dec.dec_key        = KEY;

endmodule

// File: tb/tb_aes_rx_decrypt_ctrl.sv
// Directed bench for aes_rx_decrypt_ctrl with a UART-tx responder and a table-lookup AES core stand-in.
module tb_aes_rx_decrypt_ctrl;

    localparam int           TIMEOUT = 50;
    localparam int           GAP     = 10;
    localparam logic [127:0] KEY     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] S1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] S1_PT   = 128'h00112233445566778899aabbccddeeff;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         rx_dv = 1'b0;
    logic [7:0]   rx_byte = 8'd0;
    logic         tx_dv;
    logic [7:0]   tx_byte;
    logic         tx_done;
    logic [127:0] plain_data;
    logic         frame_valid, timeout_err, overrun_err;
    logic [7:0]   frame_count;

    aes_rx_decrypt_ctrl_if dec_if ();

    aes_rx_decrypt_ctrl #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .GAP_CYCLES     (GAP),
        .KEY            (KEY)
    ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .rx_dv       (rx_dv),
        .rx_byte     (rx_byte),
        .tx_dv       (tx_dv),
        .tx_byte     (tx_byte),
        .tx_done     (tx_done),
        .plain_data  (plain_data),
        .frame_valid (frame_valid),
        .timeout_err (timeout_err),
        .overrun_err (overrun_err),
        .frame_count (frame_count),
        .dec         (dec_if)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Cycle-stamped observation of DUT activity (pre-edge values at each rising edge).
    int           cyc = 0;
    logic [7:0]   tx_byte_q[$];
    int           tx_cyc_q[$];
    int           done_cyc_q[$];
    int           dec_done_cyc = 0;
    logic [127:0] ct_at_done = '0;
    int           dec_start_n = 0, timeout_n = 0, overrun_n = 0;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (tx_dv) begin
            tx_byte_q.push_back(tx_byte);
            tx_cyc_q.push_back(cyc);
        end
        if (tx_done) done_cyc_q.push_back(cyc);
        if (dec_if.dec_done) begin
            dec_done_cyc <= cyc;
            ct_at_done   <= dec_if.dec_ciphertext;
        end
        if (dec_if.dec_start) dec_start_n <= dec_start_n + 1;
        if (timeout_err)      timeout_n   <= timeout_n + 1;
        if (overrun_err)      overrun_n   <= overrun_n + 1;
    end

    // UART transmitter stand-in: tx_done two clocks after each tx_dv.
    int tx_wait = 0;
    always @(negedge clock) begin
        tx_done = 1'b0;
        if (reset) begin
            tx_wait = 0;
        end else if (tx_wait > 0) begin
            tx_wait--;
            if (tx_wait == 0) tx_done = 1'b1;
        end
        if (tx_dv && !reset) tx_wait = 2;
    end

    // AES core stand-in: the known test vector, otherwise ct ^ key; three-clock latency.
    function automatic logic [127:0] core_model(input logic [127:0] ct, input logic [127:0] key);
        if (ct == S1_CT && key == KEY) return S1_PT;
        return ct ^ key;
    endfunction

    int           core_wait = 0;
    logic [127:0] core_ct = '0;
    always @(negedge clock) begin
        dec_if.dec_done = 1'b0;
        if (core_wait > 0) begin
            core_wait--;
            if (core_wait == 0) begin
                dec_if.dec_done      = 1'b1;
                dec_if.dec_plaintext = core_model(core_ct, dec_if.dec_key);
            end
        end
        if (dec_if.dec_start) begin
            core_ct   = dec_if.dec_ciphertext;
            core_wait = 3;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge clock);
        rx_dv   = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_tx_dv"},       tx_dv, 0);
        check({tag, "_tx_byte"},     tx_byte, 0);
        check({tag, "_plain_data"},  plain_data, 0);
        check({tag, "_frame_valid"}, frame_valid, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
        check({tag, "_overrun_err"}, overrun_err, 0);
        check({tag, "_frame_count"}, frame_count, 0);
        check({tag, "_dec_start"},   dec_if.dec_start, 0);
        check({tag, "_dec_ct"},      dec_if.dec_ciphertext, 0);
        check({tag, "_dec_key"},     dec_if.dec_key, KEY);
    endtask

    task automatic run_frame(input logic [127:0] ct, input logic [127:0] exp_pt,
                             input logic [7:0] exp_cnt, input bit do_check,
                             input int late_idx, input bit inject);
        int           k, bad, seen, to0, ov0, ds0;
        bit           injected;
        logic [127:0] got;
        tx_byte_q.delete();
        tx_cyc_q.delete();
        done_cyc_q.delete();
        to0 = timeout_n;
        ov0 = overrun_n;
        ds0 = dec_start_n;
        for (int i = 0; i < 16; i++) begin
            if (i == late_idx) repeat (TIMEOUT - 1) @(negedge clock);
            send_byte(ct[8*(15-i) +: 8]);
            if (i == 0 && do_check) check("fv_clear", frame_valid, 0);
        end
        if (do_check) begin
            check("dec_start_lat", dec_if.dec_start, 1);
            check("dec_ct", dec_if.dec_ciphertext, ct);
        end
        k = 0;
        seen = 0;
        injected = 1'b0;
        while (done_cyc_q.size() < 16 && k < 2000) begin
            @(negedge clock);
            k++;
            if (tx_dv) seen++;
            if (inject && !injected && seen == 3 && tx_dv) begin
                rx_dv    = 1'b1;
                rx_byte  = 8'ha5;
                injected = 1'b1;
            end else begin
                rx_dv = 1'b0;
            end
        end
        rx_dv = 1'b0;
        check("frame_done", done_cyc_q.size() >= 16, 1);
        repeat (4) @(negedge clock);
        if (do_check) begin
            check("plain_data", plain_data, exp_pt);
            check("frame_valid", frame_valid, 1);
            check("frame_count", frame_count, exp_cnt);
            check("tx_count", tx_byte_q.size(), 16);
            got = '0;
            foreach (tx_byte_q[i]) got = {got[119:0], tx_byte_q[i]};
            check("tx_bytes", got, exp_pt);
            check("tx_latency", (tx_cyc_q.size() > 0) ? tx_cyc_q[0] - dec_done_cyc : -1, 1);
            bad = 0;
            for (int i = 0; i < 15; i++) begin
                if (i + 1 >= tx_cyc_q.size() || i >= done_cyc_q.size()) bad++;
                else if (tx_cyc_q[i+1] - done_cyc_q[i] != GAP + 1) bad++;
            end
            check("gap", bad, 0);
            check("ct_stable", ct_at_done, ct);
            check("timeout_none", timeout_n - to0, 0);
            check("overrun", overrun_n - ov0, inject ? 1 : 0);
            check("dec_start_n", dec_start_n - ds0, 1);
        end
    endtask

    typedef struct {
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int k, to0, ds0;

        vecs[0] = '{S1_CT, S1_PT};
        vecs[1] = '{128'h0, 128'h000102030405060708090a0b0c0d0e0f};
        vecs[2] = '{{128{1'b1}}, 128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0};
        vecs[3] = '{128'h0f0e0d0c0b0a09080706050403020100, 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f};

        repeat (3) @(negedge clock);
        check_reset("por");
        reset = 1'b0;
        @(negedge clock);

        for (int v = 0; v < 4; v++) begin
            run_frame(vecs[v].ct, vecs[v].pt, 8'(v + 1), 1'b1, -1, 1'b0);
        end

        // Partial frame abandoned after exactly TIMEOUT idle clocks.
        to0 = timeout_n;
        ds0 = dec_start_n;
        for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i));
        repeat (TIMEOUT - 1) @(negedge clock);
        check("timeout_early", timeout_err, 0);
        @(negedge clock);
        check("timeout_pulse", timeout_err, 1);
        @(negedge clock);
        check("timeout_one_cycle", timeout_err, 0);
        repeat (5) @(negedge clock);
        check("timeout_count", timeout_n - to0, 1);
        check("timeout_no_start", dec_start_n - ds0, 0);
        check("timeout_fc", frame_count, 5'd4);
        check("timeout_fv", frame_valid, 0);
        check("timeout_pd", plain_data, vecs[3].pt);
        run_frame(vecs[2].ct, vecs[2].pt, 8'd5, 1'b1, -1, 1'b0);

        // Reset after the 8th tx_done abandons the send.
        tx_byte_q.delete();
        done_cyc_q.delete();
        tx_cyc_q.delete();
        for (int i = 0; i < 16; i++) send_byte(vecs[1].ct[8*(15-i) +: 8]);
        k = 0;
        while (done_cyc_q.size() < 8 && k < 2000) begin
            @(negedge clock);
            k++;
        end
        check("rst_wait", done_cyc_q.size() >= 8, 1);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check_reset("mid_send");
        reset = 1'b0;
        repeat (300) @(negedge clock);
        check("rst_no_tx", tx_byte_q.size(), 8);
        check("rst_fc", frame_count, 0);

        // A dec_done that arrives after reset is ignored.
        tx_byte_q.delete();
        for (int i = 0; i < 16; i++) send_byte(vecs[2].ct[8*(15-i) +: 8]);
        check("late_done_start", dec_if.dec_start, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (30) @(negedge clock);
        check("late_done_fc", frame_count, 0);
        check("late_done_fv", frame_valid, 0);
        check("late_done_pd", plain_data, 0);
        check("late_done_tx", tx_byte_q.size(), 0);

        run_frame(vecs[3].ct, vecs[3].pt, 8'd1, 1'b1, -1, 1'b0);
        // Second byte arrives on the very clock the inactivity timer expires.
        run_frame(vecs[0].ct, vecs[0].pt, 8'd2, 1'b1, 1, 1'b0);
        // Byte received during SEND is dropped with an overrun pulse.
        run_frame(vecs[1].ct, vecs[1].pt, 8'd3, 1'b1, -1, 1'b1);

        for (int f = 0; f < 252; f++) begin
            run_frame(vecs[f % 4].ct, vecs[f % 4].pt, 8'd0, 1'b0, -1, 1'b0);
        end
        check("fc_255", frame_count, 8'd255);
        run_frame(vecs[0].ct, vecs[0].pt, 8'd0, 1'b1, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aes_rx_decrypt_ctrl.md
AES_RX_DECRYPT_CTRL -- requirements
Module: aes_rx_decrypt_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000000, giving the maximum idle clocks between bytes inside a frame.
REQ-002 SHALL have parameter GAP_CYCLES, default 100000, giving the idle clocks between transmitted plaintext bytes.
REQ-003 SHALL have parameter KEY, default 128'h6d6120686f6f6f6f6f6e20726f686974, the decryption key.
REQ-004 clock  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 rx_dv  input  1  one-cycle strobe; rx_byte is valid (from uart_rx).
REQ-007 rx_byte  input  8  received ciphertext byte.
REQ-008 dec_start  output  1  one-cycle pulse that starts the decryption core.
REQ-009 dec_ciphertext  output  128  assembled ciphertext block to the core.
REQ-010 dec_key  output  128  constant KEY to the core.
REQ-011 dec_done  input  1  one-cycle pulse; dec_plaintext is valid.
REQ-012 dec_plaintext  input  128  decrypted block from the core.
REQ-013 tx_dv  output  1  one-cycle pulse; tx_byte is valid (to uart_tx).
REQ-014 tx_byte  output  8  plaintext byte to transmit.
REQ-015 tx_done  input  1  one-cycle pulse from uart_tx at end of byte.
REQ-016 plain_data  output  128  last decrypted block (drives display/LEDs).
REQ-017 frame_valid  output  1  high while plain_data holds a completed block.
REQ-018 timeout_err  output  1  one-cycle pulse when a partial frame is discarded.
REQ-019 overrun_err  output  1  one-cycle pulse when an rx byte is dropped.
REQ-020 frame_count  output  8  count of decrypted frames; wraps 255 to 0.

Function
REQ-021 SHALL use the states IDLE, COLLECT, DECRYPT, SEND and GAP.
REQ-022 IDLE: on rx_dv, SHALL store the byte into bits [127:120], set the byte count to 1, clear frame_valid and go to COLLECT.
REQ-023 COLLECT: each rx_dv SHALL fill the next lower byte (first byte received is the MSB) and reset the idle counter.
REQ-024 COLLECT: on the 16th byte, SHALL go to DECRYPT and pulse dec_start in the following cycle.
REQ-025 COLLECT: after TIMEOUT_CYCLES clocks with no rx_dv, SHALL discard the partial frame, pulse timeout_err and return to IDLE.
REQ-026 If rx_dv arrives in the same cycle the timeout expires, SHALL accept the byte and not raise the timeout.
REQ-027 dec_ciphertext SHALL stay stable from dec_start until dec_done.
REQ-028 DECRYPT: SHALL wait for dec_done with no limit.
REQ-029 On dec_done, SHALL capture dec_plaintext into plain_data and into the tx shift register, set frame_valid, increment frame_count, and go to SEND.
REQ-030 SEND: SHALL pulse tx_dv with the tx shift register MSB byte, shift left by 8, then wait for tx_done.
REQ-031 On tx_done, SHALL go to GAP if fewer than 16 bytes have been sent, otherwise to IDLE.
REQ-032 GAP: SHALL wait exactly GAP_CYCLES clocks, then return to SEND.
REQ-033 rx_dv in DECRYPT, SEND or GAP SHALL be dropped, SHALL pulse overrun_err, and SHALL NOT alter any frame data.
REQ-034 frame_valid and plain_data SHALL hold after the frame completes, until the first byte of the next frame.
REQ-035 Latency: dec_start SHALL occur 1 clock after the 16th rx_dv; the first tx_dv SHALL occur 1 clock after dec_done.
REQ-036 tx_dv and dec_start SHALL never be high for two consecutive cycles.

Reset
REQ-037 Reset SHALL force state IDLE.
REQ-038 Reset SHALL zero all outputs (except dec_key), all counters and all shift registers.
REQ-039 Reset mid-frame or mid-SEND SHALL abandon the operation with no further tx_dv.
REQ-040 A dec_done arriving after reset SHALL be ignored.

Structure
REQ-041 State encodings and the byte count/timeout widths SHALL live in shared package aes_uart_pkg.
REQ-042 The inactivity/gap counter SHALL be one reusable sub-module, cycle_timer (load, enable, expired).

Verification
REQ-043 Scenario 1: KEY=000102..0f; send 16 bytes 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a; core model -> plain_data=00112233445566778899aabbccddeeff; tx bytes 00,11,..,ff in order; frame_count=1.
REQ-044 Scenario 2: TIMEOUT_CYCLES=50; send 5 bytes, then idle 50 clocks -> one timeout_err pulse, no dec_start; the next 16 bytes decrypt correctly.
REQ-045 Scenario 3: send a byte during SEND -> one overrun_err pulse; transmitted bytes unchanged.
REQ-046 Scenario 4: GAP_CYCLES=10 -> exactly 10 clocks between each tx_done and the next tx_dv; 16 tx_dv per frame.
REQ-047 Scenario 5: reset asserted after the 8th tx_done -> all outputs 0, no further tx_dv; a later full frame works.
REQ-048 Scenario 6: run 256 frames -> frame_count wraps to 0.
